aes_block_sequencer: RTL and testbench
======================================

// Module: aes_block_sequencer
// PURPOSE
//  Streaming front end for the aes_128 core. Accepts 128-bit blocks on a valid/ready input,
//  feeds each block to the core, waits for its result and presents it on a valid/ready output.
//  ECB mode: core input = data block. CTR mode: core input = counter; output = keystream ^ data.
//  Sits between the bus/DMA side and aes_128 so software no longer polls start/ct_valid per block.
// PARAMETERS
//  IN_DEPTH    4    input FIFO depth in blocks; power of 2, >=2
//  WAIT_MAX    255  max cycles in WAIT before timeout (8-bit timeout counter)
// PORTS
//  wb_clk_i       in   1    clock
//  wb_rst_ni      in   1    asynchronous reset, active low
//  mode_i         in   1    0=ECB, 1=CTR; sampled at each block launch
//  key_i          in   128  cipher key; must be stable while busy_o=1
//  iv_i           in   128  CTR initial counter value
//  ctr_load_i     in   1    1-cycle pulse: counter <= iv_i
//  in_valid_i     in   1    input block valid
//  in_ready_o     out  1    input FIFO not full
//  in_data_i      in   128  input block (plaintext or ciphertext)
//  out_valid_o    out  1    result valid
//  out_ready_i    in   1    consumer accepts result
//  out_data_o     out  128  result block
//  busy_o         out  1    FSM not IDLE or FIFO not empty
//  err_o          out  1    sticky timeout flag; cleared by ctr_load_i or reset
//  aes_start_o    out  1    core start; 1-cycle pulse
//  aes_state_o    out  128  core plaintext input; held from launch until capture
//  aes_key_o      out  128  core key input (= key_i)
//  aes_out_i      in   128  core result
//  aes_valid_i    in   1    core result valid
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, counter 0, FSM IDLE, err_o 0.
//  Input FIFO: push when in_valid_i&in_ready_o; in_ready_o=0 when full. Simultaneous push+pop
//   on a full FIFO is allowed only if pop is registered first: in_ready_o reflects full only.
//  FSM states and transitions:
//   IDLE  -> LOAD when FIFO not empty; pop head into blk_q, latch mode into mode_q.
//   LOAD  : aes_state_o <= (mode_q ? ctr_q : blk_q); aes_start_o=1 for exactly this cycle; -> WAIT.
//   WAIT  : aes_valid_i is ignored in the first WAIT cycle (the core may still show the previous
//           result); from the 2nd cycle on, aes_valid_i=1 -> capture, -> HOLD.
//           Timeout counter incremented each WAIT cycle; reaching WAIT_MAX -> err_o=1, block dropped,
//           -> IDLE (counter not advanced).
//   HOLD  : out_valid_o=1, out_data_o stable until out_ready_i; on handshake -> IDLE.
//  Capture: out_data_o <= mode_q ? (aes_out_i ^ blk_q) : aes_out_i. In CTR mode, ctr_q[31:0]
//   increments by 1 at capture, wrapping 32'hFFFFFFFF -> 0; ctr_q[127:32] unchanged.
//  ctr_load_i has priority over the capture increment in the same cycle; it does not abort
//   a block in flight (that block uses the counter value sent at LOAD).
//  Throughput: 1 block per (core latency + 3) cycles with out_ready_i tied high.
//  Min in->out latency: 1 (FIFO) + 1 (LOAD) + core latency + 1 (capture) cycles.
//  Async reset mid-operation: FSM, FIFO, counter, err_o cleared immediately; in-flight block lost.
//  mode_i and key_i changes while busy_o=1 affect only blocks not yet launched.
// STRUCTURE
//  Shared package aes_pkg: AES_BLK_W=128, state encoding (IDLE/LOAD/WAIT/HOLD), MODE_ECB/MODE_CTR.
//  One sub-module: aes_seq_fifo (sync FIFO, width AES_BLK_W, depth IN_DEPTH, async active-low reset).
//  FSM, counter, timeout and output register stay in the top.
// TESTING (bench drives a behavioural aes_128 model with latency 10; FIPS-197 vector)
//  ECB: key 000102..0f, block 00112233..eeff -> out_data_o=69c4e0d86a7b0430d8cdb78070b4c55a,
//   aes_start_o pulsed exactly once.
//  CTR: iv=ctr_load 0..0_FFFFFFFE, 3 zero blocks -> outputs = E(..FFFFFFFE), E(..FFFFFFFF),
//   E(..00000000) with bits [127:32] unchanged (wrap).
//  Back-pressure: 6 blocks pushed back-to-back, out_ready_i low 50 cycles -> in_ready_o drops
//   after IN_DEPTH+1 accepts; all 6 results delivered in order, none lost or duplicated.
//  Stale-valid: aes_valid_i held high continuously -> first WAIT cycle ignored, result captured
//   in the 2nd WAIT cycle.
//  Timeout: model never asserts valid -> err_o=1 after WAIT_MAX cycles, FSM IDLE, no out_valid_o;
//   ctr_load_i clears err_o.
//  Reset mid-WAIT: wb_rst_ni low for 1 cycle -> all outputs 0 asynchronously; next block
//   processes normally.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES block sequencer and its input FIFO.
package aes_pkg;

    localparam int AES_BLK_W = 128;

    localparam logic MODE_ECB = 1'b0;
    localparam logic MODE_CTR = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } seq_state_e;

    // CTR increment touches only the low 32 bits and wraps; the nonce part is untouched.
    function automatic logic [AES_BLK_W-1:0] ctr_next(input logic [AES_BLK_W-1:0] ctr);
        return {ctr[AES_BLK_W-1:32], ctr[31:0] + 32'd1};
    endfunction

endpackage

// File: rtl/aes_block_sequencer_if.sv
// Block stream interface between the bus/DMA side (master) and the sequencer (slave).
// A beat transfers on a rising clock edge where valid and ready are both 1; once valid
// is raised the payload stays stable until that edge, and ready never depends on valid.
interface aes_block_sequencer_if;
    import aes_pkg::*;

    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [AES_BLK_W-1:0] in_data_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [AES_BLK_W-1:0] out_data_o;

    modport master (
        output in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o
    );

    modport slave (
        input  in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o
    );

endinterface

// File: rtl/aes_seq_fifo.sv
// Synchronous block FIFO; pointers carry one extra wrap bit so full and empty are unambiguous.
module aes_seq_fifo
    import aes_pkg::*;
#(
    parameter int W     = AES_BLK_W,
    parameter int DEPTH = 4
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_ni,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         full,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A push into a full FIFO is refused even if a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge wb_clk_i) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_block_sequencer.sv
// Streaming ECB/CTR front end for the aes_128 core: queues input blocks, launches each one,
// waits for the core result (with timeout) and holds it on the output stream.
module aes_block_sequencer
    import aes_pkg::*;
#(
    parameter int IN_DEPTH = 4,
    parameter int WAIT_MAX = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic                 mode_i,
    input  logic [AES_BLK_W-1:0] key_i,
    input  logic [AES_BLK_W-1:0] iv_i,
    input  logic                 ctr_load_i,
    aes_block_sequencer_if.slave bus,
    output logic                 busy_o,
    output logic                 err_o,
    output logic                 aes_start_o,
    output logic [AES_BLK_W-1:0] aes_state_o,
    output logic [AES_BLK_W-1:0] aes_key_o,
    input  logic [AES_BLK_W-1:0] aes_out_i,
    input  logic                 aes_valid_i,
    output seq_state_e           state_o
);

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    seq_state_e           state_q;
    seq_state_e           state_d;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [AES_BLK_W-1:0] fifo_dout;
    logic                 capture;
    logic                 timeout;
    logic [AES_BLK_W-1:0] blk_q;
    logic                 mode_q;
    logic [AES_BLK_W-1:0] ctr_q;
    logic [AES_BLK_W-1:0] core_in_q;
    logic [AES_BLK_W-1:0] out_data_q;
    logic [7:0]           wait_cnt_q;
    logic                 err_q;

    aes_seq_fifo #(
        .W     (AES_BLK_W),
        .DEPTH (IN_DEPTH)
    ) u_fifo (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_ni (wb_rst_ni),
        .push      (bus.in_valid_i),
        .din       (bus.in_data_i),
        .full      (fifo_full),
        .pop       (fifo_pop),
        .dout      (fifo_dout),
        .empty     (fifo_empty)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The first WAIT cycle (wait_cnt_q == 0) ignores aes_valid_i: it may still be the last result.
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        capture  = 1'b0;
        timeout  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = LOAD;
                end
            end
            LOAD: state_d = WAIT;
            WAIT: begin
                if ((wait_cnt_q != 8'd0) && aes_valid_i) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (bus.out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The core input is registered on the pop so it is already valid while aes_start_o is high.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            blk_q      <= '0;
            mode_q     <= MODE_ECB;
            core_in_q  <= '0;
            out_data_q <= '0;
            wait_cnt_q <= '0;
        end else begin
            if (fifo_pop) begin
                blk_q     <= fifo_dout;
                mode_q    <= mode_i;
                core_in_q <= (mode_i == MODE_CTR) ? ctr_q : fifo_dout;
            end
            if (state_q == WAIT) begin
                wait_cnt_q <= wait_cnt_q + 8'd1;
            end else begin
                wait_cnt_q <= '0;
            end
            if (capture) begin
                out_data_q <= (mode_q == MODE_CTR) ? (aes_out_i ^ blk_q) : aes_out_i;
            end
        end
    end

    // A reload wins over the capture increment; the block in flight already has its counter.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ctr_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (ctr_load_i) begin
                ctr_q <= iv_i;
            end else if (capture && (mode_q == MODE_CTR)) begin
                ctr_q <= ctr_next(ctr_q);
            end
            if (ctr_load_i) begin
                err_q <= 1'b0;
            end else if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.in_ready_o  = !fifo_full && wb_rst_ni;
    assign bus.out_valid_o = (state_q == HOLD);
    assign bus.out_data_o  = out_data_q;
    assign busy_o          = (state_q != IDLE) || !fifo_empty;
    assign err_o           = err_q;
    assign aes_start_o     = (state_q == LOAD);
    assign aes_state_o     = core_in_q;
    assign aes_key_o       = key_i;
    assign state_o         = state_q;

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Bench for aes_block_sequencer: behavioural aes_128 core model plus an in-order output scoreboard.
module tb_aes_block_sequencer;
    import aes_pkg::*;

    localparam int IN_DEPTH = 4;
    localparam int WAIT_MAX = 255;
    localparam int CORE_LAT = 10;

    logic           wb_clk_i = 1'b0;
    logic           wb_rst_ni;
    logic           mode_i;
    logic [127:0]   key_i;
    logic [127:0]   iv_i;
    logic           ctr_load_i;
    logic           busy_o;
    logic           err_o;
    logic           aes_start_o;
    logic [127:0]   aes_state_o;
    logic [127:0]   aes_key_o;
    logic [127:0]   aes_out_i = '0;
    logic           aes_valid_i = 1'b0;
    seq_state_e     state_o;

    aes_block_sequencer_if bus ();

    aes_block_sequencer #(
        .IN_DEPTH (IN_DEPTH),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_ni   (wb_rst_ni),
        .mode_i      (mode_i),
        .key_i       (key_i),
        .iv_i        (iv_i),
        .ctr_load_i  (ctr_load_i),
        .bus         (bus),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .aes_start_o (aes_start_o),
        .aes_state_o (aes_state_o),
        .aes_key_o   (aes_key_o),
        .aes_out_i   (aes_out_i),
        .aes_valid_i (aes_valid_i),
        .state_o     (state_o)
    );

    // ---------------- clock ----------------
    always #5 wb_clk_i = ~wb_clk_i;

    // ---------------- AES-128 reference ----------------
    logic [7:0] sbox_t [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] base;
        logic [7:0] e;
        inv  = 8'h01;
        base = x;
        e    = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) inv = gmul(inv, base);
            base = gmul(base, base);
        end
        if (x == 8'h00) inv = 8'h00;
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]}
                      ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) t[4*c+rr] = s[4*((c+rr)%4)+rr];
            for (int i = 0; i < 16; i++) s[i] = t[i];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- behavioural aes_128 core ----------------
    int           m_cnt   = 0;
    int           m_lat   = CORE_LAT;
    logic [127:0] m_res   = '0;
    logic         m_mute  = 1'b0;
    logic         m_stale = 1'b0;

    always @(posedge wb_clk_i) begin
        logic v_next;
        v_next = m_stale;
        if (aes_start_o) begin
            m_res = aes_encrypt(aes_key_o, aes_state_o);
            m_cnt = m_lat;
        end else if (m_cnt != 0) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0 && !m_mute) begin
                aes_out_i <= m_res;
                v_next = 1'b1;
            end
        end
        aes_valid_i <= v_next;
    end

    // ---------------- scoreboard ----------------
    logic [127:0] exp_q [$];
    logic [127:0] mon_exp;
    int           checks    = 0;
    int           errors    = 0;
    int           out_cnt   = 0;
    int           start_cnt = 0;

    always @(negedge wb_clk_i) begin
        #1;
        if (wb_rst_ni && bus.out_valid_o && bus.out_ready_i) begin
            checks++;
            out_cnt++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected got=%h required=none", bus.out_data_o);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.out_data_o !== mon_exp) begin
                    errors++;
                    $display("FAIL out_data got=%h required=%h", bus.out_data_o, mon_exp);
                end
            end
        end
        if (wb_rst_ni && aes_start_o) start_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge wb_clk_i);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic push_one(input logic [127:0] d, input logic has_exp, input logic [127:0] e);
        int n;
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = d;
        n = 0;
        while (!bus.in_ready_o && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (!bus.in_ready_o) begin
            errors++;
            $display("FAIL push_timeout got=in_ready_low required=accept");
        end else if (has_exp) begin
            exp_q.push_back(e);
        end
        tick();
        bus.in_valid_i = 1'b0;
    endtask

    task automatic pulse_ctr_load(input logic [127:0] iv);
        iv_i       = iv;
        ctr_load_i = 1'b1;
        tick();
        ctr_load_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy_o) && n < 3000) begin
            tick();
            n++;
        end
        tick();
        checks++;
        if (exp_q.size() != 0 || busy_o) begin
            errors++;
            $display("FAIL drain got=pending_%0d required=0", exp_q.size());
        end
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (!aes_start_o && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (!aes_start_o) begin
            errors++;
            $display("FAIL wait_start got=no_start required=start");
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [7:0] flags;
        wb_rst_ni = 1'b0;
        repeat (3) tick();
        flags = {bus.out_valid_o, busy_o, err_o, aes_start_o, bus.in_ready_o, 1'b0, state_o};
        checks++;
        if (flags !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags got=%b required=%b", flags, 8'h00);
        end
        checks++;
        if (bus.out_data_o !== 128'h0) begin
            errors++;
            $display("FAIL reset_out_data got=%h required=0", bus.out_data_o);
        end
        checks++;
        if (aes_state_o !== 128'h0) begin
            errors++;
            $display("FAIL reset_aes_state got=%h required=0", aes_state_o);
        end
        wb_rst_ni = 1'b1;
        tick();
        checks++;
        if (bus.in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b required=1", bus.in_ready_o);
        end
    endtask

    task automatic test_ecb();
        int s0;
        mode_i = MODE_ECB;
        s0 = start_cnt;
        push_one(128'h00112233445566778899aabbccddeeff, 1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        drain();
        checks++;
        if (start_cnt - s0 != 1) begin
            errors++;
            $display("FAIL ecb_start_count got=%0d required=1", start_cnt - s0);
        end
        checks++;
        if (aes_key_o !== 128'h000102030405060708090a0b0c0d0e0f) begin
            errors++;
            $display("FAIL ecb_key got=%h required=000102030405060708090a0b0c0d0e0f", aes_key_o);
        end
    endtask

    task automatic test_ctr();
        logic [127:0] ctr_vals [3];
        ctr_vals[0] = {96'h0, 32'hFFFFFFFE};
        ctr_vals[1] = {96'h0, 32'hFFFFFFFF};
        ctr_vals[2] = {96'h0, 32'h00000000};
        mode_i = MODE_CTR;
        pulse_ctr_load({96'h0, 32'hFFFFFFFE});
        for (int i = 0; i < 3; i++) push_one(128'h0, 1'b1, aes_encrypt(key_i, ctr_vals[i]));
        drain();
    endtask

    task automatic test_back_to_back();
        int first_stall;
        int o0;
        logic [127:0] d;
        mode_i          = MODE_ECB;
        first_stall     = -1;
        o0              = out_cnt;
        bus.out_ready_i = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    if (!bus.in_ready_o && first_stall < 0) first_stall = i;
                    d = rand128();
                    push_one(d, 1'b1, aes_encrypt(key_i, d));
                end
            end
            begin
                repeat (50) tick();
                bus.out_ready_i = 1'b1;
            end
        join
        drain();
        checks++;
        if (first_stall != IN_DEPTH + 1) begin
            errors++;
            $display("FAIL bp_accepts_before_full got=%0d required=%0d", first_stall, IN_DEPTH + 1);
        end
        checks++;
        if (out_cnt - o0 != 6) begin
            errors++;
            $display("FAIL bp_out_count got=%0d required=6", out_cnt - o0);
        end
    endtask

    task automatic test_stale_valid();
        logic [127:0] d;
        logic [3:0]   obs;
        mode_i  = MODE_ECB;
        m_lat   = 1;
        m_stale = 1'b1;
        d = rand128();
        push_one(d, 1'b1, aes_encrypt(key_i, d));
        wait_start();
        tick();
        obs[3:2] = {bus.out_valid_o, state_o == WAIT};
        tick();
        obs[1:0] = {bus.out_valid_o, state_o == WAIT};
        checks++;
        if (obs !== 4'b0101) begin
            errors++;
            $display("FAIL stale_wait_cycles got=%b required=0101", obs);
        end
        tick();
        checks++;
        if (bus.out_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL stale_capture got=%b required=1", bus.out_valid_o);
        end
        m_stale = 1'b0;
        m_lat   = CORE_LAT;
        drain();
    endtask

    task automatic test_timeout();
        int n;
        logic saw_valid;
        logic [127:0] d;
        mode_i = MODE_CTR;
        pulse_ctr_load({96'h0, 32'h10});
        m_mute = 1'b1;
        push_one(rand128(), 1'b0, 128'h0);
        wait_start();
        n = 0;
        saw_valid = 1'b0;
        while (!err_o && n < 600) begin
            tick();
            n++;
            if (bus.out_valid_o) saw_valid = 1'b1;
        end
        checks++;
        if (n != WAIT_MAX + 1) begin
            errors++;
            $display("FAIL timeout_cycles got=%0d required=%0d", n, WAIT_MAX + 1);
        end
        checks++;
        if ({saw_valid, busy_o, state_o} !== {1'b0, 1'b0, IDLE}) begin
            errors++;
            $display("FAIL timeout_state got=%b%b%0d required=00%0d", saw_valid, busy_o, state_o, IDLE);
        end
        m_mute = 1'b0;
        d = rand128();
        push_one(d, 1'b1, aes_encrypt(key_i, {96'h0, 32'h10}) ^ d);
        drain();
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_err_sticky got=%b required=1", err_o);
        end
        pulse_ctr_load(128'h0);
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err_clear got=%b required=0", err_o);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [7:0]   flags;
        logic [127:0] d;
        mode_i = MODE_ECB;
        push_one(rand128(), 1'b0, 128'h0);
        wait_start();
        repeat (3) tick();
        wb_rst_ni = 1'b0;
        #1;
        flags = {bus.out_valid_o, busy_o, err_o, aes_start_o, bus.in_ready_o, 1'b0, state_o};
        checks++;
        if (flags !== 8'h00) begin
            errors++;
            $display("FAIL midreset_flags got=%b required=%b", flags, 8'h00);
        end
        checks++;
        if ({bus.out_data_o, aes_state_o} !== 256'h0) begin
            errors++;
            $display("FAIL midreset_data got=%h_%h required=0", bus.out_data_o, aes_state_o);
        end
        tick();
        wb_rst_ni = 1'b1;
        tick();
        d = rand128();
        push_one(d, 1'b1, aes_encrypt(key_i, d));
        drain();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
        wb_rst_ni       = 1'b0;
        mode_i          = MODE_ECB;
        key_i           = 128'h000102030405060708090a0b0c0d0e0f;
        iv_i            = 128'h0;
        ctr_load_i      = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = 128'h0;
        bus.out_ready_i = 1'b1;

        test_reset();
        test_ecb();
        test_ctr();
        test_back_to_back();
        test_stale_valid();
        test_timeout();
        test_reset_mid_wait();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
